// File: rtl/recur_pkg.sv
// Shared definitions for the recurrence controller and its datapath:
// state codes, default sizing constants and a small state-class helper.
package recur_pkg;

  localparam int DEF_SIZE    = 4;
  localparam int DEF_MAX_N   = 15;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_STEP_W  = 10;

  typedef logic [3:0] state_t;

  localparam state_t IDLE      = 4'd0;
  localparam state_t INIT      = 4'd1;
  localparam state_t EVAL      = 4'd2;
  localparam state_t PUSH      = 4'd3;
  localparam state_t WAIT_PUSH = 4'd4;
  localparam state_t POP       = 4'd5;
  localparam state_t CALC      = 4'd6;
  localparam state_t WAIT_CAL  = 4'd7;
  localparam state_t RESUPD    = 4'd8;
  localparam state_t FINISH    = 4'd9;
  localparam state_t ERROR     = 4'd10;

  // States in which the controller waits on a datapath acknowledge.
  function automatic logic is_wait(input state_t s);
    return (s == WAIT_PUSH) || (s == WAIT_CAL);
  endfunction

endpackage

// File: rtl/recur_watchdog.sv
// Per-state watchdog: counts cycles while enabled and flags expiry on the
// TIMEOUT-th consecutive enabled cycle so the FSM can leave on that edge.
module recur_watchdog
  import recur_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Expiry is combinational so an acknowledge in the same cycle can still win.
  assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

  // Cycle counter, restarted on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/recur_controller.sv
// Control FSM for the recurrence datapath value[n] = 2*value[n-1] + 3*value[n-2].
// Issues one-cycle registered strobes, consumes datapath status, and provides a
// start/busy/result_valid handshake with watchdog error and alu step counting.
module recur_controller
  import recur_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int MAX_N   = DEF_MAX_N,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int STEP_W  = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   entry,
  input  logic              updated,
  input  logic              done,
  input  logic              backtrack,
  input  logic              cal_update,
  output logic              load_init,
  output logic              alu,
  output logic              updater,
  output logic              poping,
  output logic              cal_res,
  output logic              res_updater,
  output logic              busy,
  output logic              result_valid,
  output logic              error,
  output logic [STEP_W-1:0] steps
);

  state_t          state;
  state_t          next_state;
  logic [SIZE-1:0] entry_q;
  logic            first_eval;
  logic            start_ok;
  logic            start_bad;
  logic            wd_expired;

  assign start_ok  = (state == IDLE) && start && (int'(entry) <= MAX_N);
  assign start_bad = (state == IDLE) && start && (int'(entry) >  MAX_N);

  recur_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (next_state != state),
    .enable  (is_wait(state)),
    .expired (wd_expired)
  );

  // Next-state decode; status inputs are only looked at in their consuming state.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    next_state = state;
    case (state)
      IDLE:      if (start_ok) next_state = INIT;
      INIT:      next_state = (entry_q <= SIZE'(1)) ? FINISH : EVAL;
      EVAL: begin
        if (done && !first_eval) next_state = FINISH;
        else if (backtrack)      next_state = CALC;
        else                     next_state = PUSH;
      end
      PUSH:      next_state = WAIT_PUSH;
      WAIT_PUSH: begin
        if (updated)         next_state = POP;
        else if (wd_expired) next_state = ERROR;
      end
      POP:       next_state = EVAL;
      CALC:      next_state = WAIT_CAL;
      WAIT_CAL: begin
        if (cal_update)      next_state = RESUPD;
        else if (wd_expired) next_state = ERROR;
      end
      RESUPD:    next_state = EVAL;
      FINISH:    next_state = IDLE;
      ERROR:     next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // State register and Moore outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      load_init    <= 1'b0;
      alu          <= 1'b0;
      updater      <= 1'b0;
      poping       <= 1'b0;
      cal_res      <= 1'b0;
      res_updater  <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state        <= next_state;
      load_init    <= (next_state == INIT);
      alu          <= (next_state == EVAL);
      updater      <= (next_state == PUSH);
      poping       <= (next_state == POP);
      cal_res      <= (next_state == CALC);
      res_updater  <= (next_state == RESUPD);
      result_valid <= (next_state == FINISH);
      busy         <= (next_state != IDLE);
    end
  end

  // Run context: latched entry, first-evaluation flag, sticky error level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q    <= '0;
      first_eval <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (start_ok) begin
        entry_q <= entry;
        error   <= 1'b0;
      end else if (start_bad || next_state == ERROR) begin
        error <= 1'b1;
      end
      if (state == INIT)      first_eval <= 1'b1;
      else if (state == EVAL) first_eval <= 1'b0;
    end
  end

  // Saturating count of alu strobes, tracking the alu output cycle for cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      steps <= '0;
    end else if (start_ok) begin
      steps <= '0;
    end else if (next_state == EVAL && steps != {STEP_W{1'b1}}) begin
      steps <= steps + STEP_W'(1);
    end
  end

endmodule
